// File: rtl/code_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the code-entry sequencer.
// Timing defaults assume a 25 MHz system clock.
package code_sequencer_pkg;

    localparam int KEY_W  = 8;
    localparam int CLK_HZ = 25_000_000;

    localparam int TIMEOUT_CYCLES_DEF = CLK_HZ;       // 1 s
    localparam int UNLOCK_CYCLES_DEF  = 5 * CLK_HZ;   // 5 s
    localparam int LOCKOUT_CYCLES_DEF = 10 * CLK_HZ;  // 10 s

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_ALARM    = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/code_sequencer_if.sv
// Bus between the key sanitizer / lock control and the code sequencer.
// key_in and lock_req are level signals valid every cycle (no ready); a press is a
// nonzero key seen after a zero. All sequencer outputs are registered.
interface code_sequencer_if
    import code_sequencer_pkg::*;
#(
    parameter int FAIL_W = 2
);
    logic [KEY_W-1:0]  key_in;
    logic              lock_req;
    logic              unlocked;
    logic              alarm;
    logic              entry_active;
    logic [FAIL_W-1:0] fail_count;
    state_e            dbg_state;

    modport master (
        output key_in, lock_req,
        input  unlocked, alarm, entry_active, fail_count, dbg_state
    );

    modport slave (
        input  key_in, lock_req,
        output unlocked, alarm, entry_active, fail_count, dbg_state
    );
endinterface

// File: rtl/code_sequencer_key_press_detect.sv
// Turns the level key bus into single press events: a press needs a zero cycle first,
// so a held key yields exactly one event. clear disarms when the sequencer returns to IDLE.
module key_press_detect
    import code_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             clear,
    output logic             press,
    output logic [KEY_W-1:0] key_val
);
    logic armed_q;
    logic armed_d;

    // The strobe is same-cycle so the sequencer can register its result on the press edge.
    assign press   = armed_q && (key_in != '0);
    assign key_val = key_in;

    always_comb begin
        armed_d = armed_q;
        if (clear || press) begin
            armed_d = 1'b0;
        end else if (key_in == '0) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
endmodule

// File: rtl/code_sequencer.sv
// Code-entry FSM: constant-time compare of SEQ_LEN key presses against SECRET,
// timed unlock, and alarm lockout after MAX_FAILS consecutive bad codes.
module code_sequencer
    import code_sequencer_pkg::*;
#(
    parameter int                         SEQ_LEN        = 4,
    parameter logic [KEY_W*SEQ_LEN-1:0]   SECRET         = 32'h08_04_02_01,
    parameter int                         MAX_FAILS      = 3,
    parameter int                         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int                         UNLOCK_CYCLES  = UNLOCK_CYCLES_DEF,
    parameter int                         LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    code_sequencer_if.slave bus
);
    localparam int IDX_W   = $clog2(SEQ_LEN) + 1;
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_MAX = max3(TIMEOUT_CYCLES, UNLOCK_CYCLES, LOCKOUT_CYCLES);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]  TO_TC    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  UL_TC    = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LO_TC    = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_SAT  = TMR_W'(TMR_MAX - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SEQ_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              mis_q, mis_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic              unlocked_q, unlocked_d;
    logic              alarm_q, alarm_d;
    logic              entry_q, entry_d;

    logic              press;
    logic [KEY_W-1:0]  key_val;
    logic              clear_arm;
    logic              take;
    logic [IDX_W-1:0]  cur_idx;
    logic [KEY_W-1:0]  exp_key;
    logic              mis_new;
    logic              is_final;
    logic [FAIL_W-1:0] fail_inc;

    key_press_detect u_kpd (
        .clk     (clk),
        .rst     (rst),
        .key_in  (bus.key_in),
        .clear   (clear_arm),
        .press   (press),
        .key_val (key_val)
    );

    // Mismatches only accumulate; the verdict is taken on the final entry alone.
    always_comb begin
        cur_idx  = (state_q == ST_ENTRY) ? idx_q : '0;
        exp_key  = KEY_W'(SECRET >> (KEY_W * int'(cur_idx)));
        mis_new  = ((state_q == ST_ENTRY) && mis_q) || (key_val != exp_key);
        is_final = (cur_idx == LAST_IDX);
        fail_inc = fail_q + FAIL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            mis_q      <= 1'b0;
            timer_q    <= '0;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            entry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mis_q      <= mis_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
            entry_q    <= entry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        fail_d  = fail_q;
        timer_d = (timer_q == TMR_SAT) ? timer_q : timer_q + TMR_W'(1);
        take    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take = press;
            end
            ST_ENTRY: begin
                // lock_req beats a simultaneous press; a press beats the timeout.
                if (bus.lock_req) begin
                    state_d = ST_IDLE;
                end else if (press) begin
                    take = 1'b1;
                end else if (timer_q == TO_TC) begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNLOCKED: begin
                if (bus.lock_req || (timer_q == UL_TC)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (timer_q == LO_TC) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            timer_d = '0;
            if (is_final) begin
                if (!mis_new) begin
                    state_d = ST_UNLOCKED;
                    fail_d  = '0;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == FAIL_MAX) ? ST_ALARM : ST_IDLE;
                end
            end else begin
                state_d = ST_ENTRY;
                idx_d   = cur_idx + IDX_W'(1);
                mis_d   = mis_new;
            end
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end

        clear_arm = (state_d == ST_IDLE) && (state_q != ST_IDLE);
        if (clear_arm) begin
            idx_d = '0;
            mis_d = 1'b0;
        end
    end

    always_comb begin
        unlocked_d = (state_d == ST_UNLOCKED);
        alarm_d    = (state_d == ST_ALARM);
        entry_d    = (state_d == ST_ENTRY);
    end

    assign bus.unlocked     = unlocked_q;
    assign bus.alarm        = alarm_q;
    assign bus.entry_active = entry_q;
    assign bus.fail_count   = fail_q;
    assign bus.dbg_state    = state_q;
endmodule
